// File: rtl/hps_vector_engine.sv
// hps_vector_engine: HPS-driven element-wise vector ALU over a 4-phase req/ack PIO handshake
module hps_vector_engine #(
   parameter int DATA_W      = 8,
   parameter int VEC_LEN     = 8,
   parameter int TIMEOUT_CYC = 1000000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] data_in,
   output logic [31:0] data_out,
   output logic [5:0]  debug_state
);
   localparam int AW = (VEC_LEN > 1) ? $clog2(VEC_LEN) : 1;
   localparam int IW = $clog2(2 * VEC_LEN) + 1;
   localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      RX_REQ  = 3'd1,
      RX_DROP = 3'd2,
      PROCESS = 3'd3,
      TX_REQ  = 3'd4,
      TX_DROP = 3'd5
   } state_t;
   state_t state, state_nxt;
   logic [IW-1:0] idx;
   logic [TW-1:0] cnt;
   logic [1:0] op;
   logic ack, done, tmo, ovf;
   logic [2:0] req_sh, start_sh;
   logic req_rise, req_fall, start_rise, xfer, tx, tmo_hit, last_rx, last_el, wr_a;
   logic [AW-1:0] b_idx;
   logic [DATA_W-1:0] a_mem [2**AW];
   logic [DATA_W-1:0] b_mem [2**AW];
   logic [DATA_W-1:0] r_mem [2**AW];
   logic [DATA_W-1:0] a_el, b_el, res;
   logic [DATA_W:0] sum, diff;
   logic [2*DATA_W-1:0] prod;
   logic res_ovf;
   logic unused_bits;
   assign unused_bits = ^data_in[27:DATA_W];
   assign req_rise   = req_sh[1] & ~req_sh[2];
   assign req_fall   = ~req_sh[1] & req_sh[2];
   assign start_rise = start_sh[1] & ~start_sh[2];
   assign xfer    = state == RX_REQ || state == RX_DROP || state == TX_REQ || state == TX_DROP;
   assign tx      = state == TX_REQ || state == TX_DROP;
   assign tmo_hit = xfer && !req_rise && !req_fall && cnt == TW'(TIMEOUT_CYC - 1);
   assign last_rx = idx == IW'(2 * VEC_LEN - 1);
   assign last_el = idx == IW'(VEC_LEN - 1);
   assign wr_a    = idx < IW'(VEC_LEN);
   assign b_idx   = AW'(idx - IW'(VEC_LEN));
   assign a_el = a_mem[idx[AW-1:0]];
   assign b_el = b_mem[idx[AW-1:0]];
   assign sum  = {1'b0, a_el} + {1'b0, b_el};
   assign diff = {1'b0, a_el} - {1'b0, b_el};
   assign prod = (2 * DATA_W)'(a_el) * (2 * DATA_W)'(b_el);
   // element ALU: truncated result plus the per-opcode overflow condition
   always_comb begin
      res = op == 2'd0 ? sum[DATA_W-1:0] : op == 2'd1 ? diff[DATA_W-1:0] :
            op == 2'd2 ? prod[DATA_W-1:0] : (a_el > b_el ? a_el : b_el);
      res_ovf = op == 2'd0 ? sum[DATA_W] : op == 2'd1 ? diff[DATA_W] :
                op == 2'd2 ? |prod[2*DATA_W-1:DATA_W] : 1'b0;
   end
   // next-state logic; a timeout in any transfer state forces a return to IDLE
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_rise) state_nxt = RX_REQ;
         RX_REQ:  if (req_rise) state_nxt = RX_DROP;
         RX_DROP: if (req_fall) state_nxt = last_rx ? PROCESS : RX_REQ;
         PROCESS: if (last_el) state_nxt = TX_REQ;
         TX_REQ:  if (req_rise) state_nxt = TX_DROP;
         TX_DROP: if (req_fall) state_nxt = last_el ? IDLE : TX_REQ;
         default: state_nxt = IDLE;
      endcase
      if (tmo_hit) state_nxt = IDLE;
   end
   // state register
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_nxt;
   // synchronisers, index, handshake ack, timeout counter and sticky status flags
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         req_sh   <= '0;
         start_sh <= '0;
         idx      <= '0;
         cnt      <= '0;
         op       <= '0;
         ack      <= 1'b0;
         done     <= 1'b0;
         tmo      <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         req_sh   <= {req_sh[1:0], data_in[31]};
         start_sh <= {start_sh[1:0], data_in[30]};
         cnt      <= (xfer && !req_rise && !req_fall && !tmo_hit) ? cnt + 1'b1 : '0;
         if (tmo_hit) begin
            tmo <= 1'b1;
            ack <= 1'b0;
         end else
            case (state)
               IDLE: if (start_rise) begin
                  op   <= data_in[29:28];
                  done <= 1'b0;
                  tmo  <= 1'b0;
                  ovf  <= 1'b0;
                  idx  <= '0;
               end
               RX_REQ: if (req_rise) ack <= 1'b1;
               RX_DROP: if (req_fall) begin
                  ack <= 1'b0;
                  idx <= last_rx ? '0 : idx + 1'b1;
               end
               PROCESS: begin
                  ovf <= ovf | res_ovf;
                  idx <= last_el ? '0 : idx + 1'b1;
               end
               TX_REQ: if (req_rise) ack <= 1'b1;
               TX_DROP: if (req_fall) begin
                  ack <= 1'b0;
                  if (last_el) done <= 1'b1;
                  else idx <= idx + 1'b1;
               end
               default: ack <= 1'b0;
            endcase
      end
   // operand and result storage, no reset needed
   always_ff @(posedge clk) begin
      if (state == RX_REQ && req_rise && wr_a) a_mem[idx[AW-1:0]] <= data_in[DATA_W-1:0];
      if (state == RX_REQ && req_rise && !wr_a) b_mem[b_idx] <= data_in[DATA_W-1:0];
      if (state == PROCESS) r_mem[idx[AW-1:0]] <= res;
   end
   assign data_out = {ack, state != IDLE, done, tmo, ovf, state, 8'(idx),
                      tx ? 16'(r_mem[idx[AW-1:0]]) : 16'd0};
   assign debug_state = 6'd1 << state;
endmodule

// File: tb/tb_hps_vector_engine.sv
// tb_hps_vector_engine: randomized handshake-level bench against an arithmetic reference model
module tb_hps_vector_engine;
   localparam int DW = 8, VL = 8, TO = 100;
   logic clk = 0, reset = 1;
   logic [31:0] data_in = '0, data_out;
   logic [5:0] debug_state;
   int errors = 0, checks = 0;
   int a[VL], b[VL];
   hps_vector_engine #(.DATA_W(DW), .VEC_LEN(VL), .TIMEOUT_CYC(TO)) dut (
      .clk(clk), .reset(reset), .data_in(data_in), .data_out(data_out), .debug_state(debug_state));
   always #5 clk = ~clk;
   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog");
   end
   task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic wait_ack(logic lvl, string tag, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (data_out[31] !== lvl && n < 50);
      chk(tag, data_out[31], lvl);
   endtask
   task automatic hs(logic [1:0] op, int payload);
      int n;
      @(negedge clk);
      data_in = {1'b1, 1'b0, op, 28'(payload)};
      wait_ack(1'b1, "ack_rise", n);
      chk("ack_rise_lat", n >= 2 && n <= 3, 1);
      @(negedge clk);
      chk("ack_hold", data_out[31], 1);
      data_in[31] = 1'b0;
      wait_ack(1'b0, "ack_fall", n);
      chk("ack_fall_lat", n >= 2 && n <= 3, 1);
   endtask
   task automatic start(logic [1:0] op, bit with_req);
      @(negedge clk);
      data_in = {with_req, 1'b1, op, 28'd0};
      repeat (4) @(negedge clk);
      data_in[30] = 1'b0;
   endtask
   task automatic run_vec(logic [1:0] op, int glitch_at, bit both, int abort_at);
      int n, s, ov;
      int r[VL];
      logic [1:0] opw;
      opw = op;
      ov = 0;
      for (int i = 0; i < VL; i++) begin
         case (op)
            2'd0: begin s = a[i] + b[i]; r[i] = s % 256; if (s > 255) ov = 1; end
            2'd1: begin r[i] = (a[i] - b[i]) & 255; if (a[i] < b[i]) ov = 1; end
            2'd2: begin s = a[i] * b[i]; r[i] = s % 256; if (s > 255) ov = 1; end
            default: r[i] = a[i] > b[i] ? a[i] : b[i];
         endcase
      end
      start(op, both);
      tick();
      chk("busy_after_start", data_out[30], 1);
      chk("flags_cleared", data_out[29:27], 0);
      if (both) begin
         repeat (6) tick();
         chk("both_no_ack", data_out[31], 0);
         chk("both_state", data_out[26:24], 1);
         @(negedge clk);
         data_in[31] = 1'b0;
         repeat (4) tick();
      end
      for (int i = 0; i < 2 * VL; i++) begin
         if (i == glitch_at) begin
            @(negedge clk);
            data_in = {1'b0, 1'b1, 2'b11, 28'd0};
            repeat (4) @(negedge clk);
            data_in[30] = 1'b0;
            tick();
            chk("glitch_state", data_out[26:24], 1);
            chk("glitch_idx", data_out[23:16], i);
            opw = 2'b11;
         end
         hs(opw, i < VL ? a[i] : b[i-VL]);
      end
      n = 0;
      do begin
         tick();
         n++;
      end while (data_out[26:24] !== 3'd4 && n < 100);
      chk("process_lat", n, VL);
      for (int i = 0; i < VL; i++) begin
         chk("tx_state", data_out[26:24], 4);
         chk("tx_idx", data_out[23:16], i);
         chk("result", data_out[15:0], r[i]);
         if (i == abort_at) begin
            @(negedge clk);
            data_in[31] = 1'b1;
            wait_ack(1'b1, "abort_ack", n);
            chk("abort_in_tx_drop", data_out[26:24], 5);
            #2 reset = 1'b0;
            #1;
            chk("abort_data_out", data_out, 0);
            chk("abort_debug", debug_state, 6'b000001);
            data_in = '0;
            @(negedge clk);
            reset = 1'b1;
            return;
         end
         hs(opw, 0);
      end
      chk("done", data_out[29], 1);
      chk("busy_end", data_out[30], 0);
      chk("overflow", data_out[27], ov);
      chk("timeout_clear", data_out[28], 0);
      chk("end_state", data_out[26:24], 0);
      chk("end_debug", debug_state, 6'b000001);
   endtask
   task automatic rand_ab(int amax, int bmax);
      for (int i = 0; i < VL; i++) begin
         a[i] = int'($urandom_range(0, amax));
         b[i] = int'($urandom_range(0, bmax));
      end
   endtask
   initial begin
      int n;
      #2 reset = 1'b0;
      #2;
      chk("reset_data_out", data_out, 0);
      chk("reset_debug", debug_state, 6'b000001);
      #17 reset = 1'b1;
      for (int i = 0; i < VL; i++) begin a[i] = i + 1; b[i] = i + 10; end
      run_vec(2'd0, -1, 0, -1);
      for (int i = 0; i < VL; i++) begin a[i] = 0; b[i] = 0; end
      a[0] = 200; b[0] = 100;
      run_vec(2'd0, -1, 0, -1);
      for (int i = 0; i < VL; i++) begin a[i] = 16; b[i] = 17; end
      run_vec(2'd2, -1, 0, -1);
      for (int i = 0; i < VL; i++) begin a[i] = 5; b[i] = 7; end
      run_vec(2'd1, -1, 0, -1);
      rand_ab(100, 100);
      run_vec(2'd0, 3, 0, -1);
      rand_ab(255, 255);
      run_vec(2'd2, -1, 1, -1);
      for (int k = 0; k < 8; k++) begin
         if (k < 4) rand_ab(255, 255);
         else rand_ab(15, 15);
         run_vec(2'(k), -1, 0, -1);
      end
      start(2'd0, 0);
      for (int i = 0; i < 3; i++) hs(2'd0, i);
      n = 0;
      do begin
         tick();
         n++;
      end while (data_out[28] !== 1'b1 && n < 300);
      chk("timeout_lat", n >= 98 && n <= 102, 1);
      chk("timeout_flag", data_out[28], 1);
      chk("timeout_ack", data_out[31], 0);
      chk("timeout_state", data_out[26:24], 0);
      chk("timeout_done", data_out[29], 0);
      chk("timeout_busy", data_out[30], 0);
      start(2'd1, 0);
      tick();
      chk("timeout_cleared_by_start", data_out[28], 0);
      chk("restart_busy", data_out[30], 1);
      #2 reset = 1'b0;
      #1;
      chk("abort_rx_data_out", data_out, 0);
      @(negedge clk);
      reset = 1'b1;
      rand_ab(255, 255);
      run_vec(2'd3, -1, 0, 2);
      rand_ab(255, 255);
      run_vec(2'd0, -1, 0, -1);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
